// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated doubleword data-memory responder.
package dmem_pkg;

    localparam int unsigned DWORD_W    = 64;
    localparam int unsigned BYTE_OFF_W = 3;
    localparam int unsigned LAT_MIN    = 1;
    localparam int unsigned LAT_MAX    = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic               write;
        logic [DWORD_W-1:0] addr;
        logic [DWORD_W-1:0] wdata;
    } dmem_req_t;

    // Misaligned, or doubleword index beyond the idx_w-bit array.
    function automatic logic addr_err(input logic [DWORD_W-1:0] addr, input int unsigned idx_w);
        return (addr[BYTE_OFF_W-1:0] != '0) || ((addr >> (BYTE_OFF_W + idx_w)) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage with a synchronous write port and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [DWORD_W-1:0]       wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [DWORD_W-1:0]       rdata
);

    logic [DWORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata holds between reads.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: valid/ready request, LATENCY wait states, held response.
// One request in flight at a time, so read-after-write ordering is preserved.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [DWORD_W-1:0] req_addr,
    input  logic [DWORD_W-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DWORD_W-1:0] rsp_rdata,
    output logic               rsp_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    generate
        if ((LATENCY < LAT_MIN) || (LATENCY > LAT_MAX)) begin : g_bad_latency
            $error("dmem_responder: LATENCY out of range 1..15");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("dmem_responder: DEPTH must be a power of two >= 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    dmem_req_t          req_q, req_d, req_live, rd_req;
    logic               ready_d, valid_d, error_d;
    logic [DWORD_W-1:0] rdata_d;
    logic               go_commit, commit_err;
    logic               arr_we, arr_re;
    logic [DWORD_W-1:0] arr_rdata;

    assign req_live   = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign commit_err = addr_err(req_q.addr, IDX_W);

    // The array read is launched on the edge entering COMMIT so its data is
    // ready to be registered into rsp_rdata on the COMMIT edge itself.
    assign rd_req = (state_q == IDLE) ? req_live : req_q;
    assign arr_re = go_commit && !rd_req.write && !addr_err(rd_req.addr, IDX_W);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        ready_d   = req_ready;
        valid_d   = rsp_valid;
        rdata_d   = rsp_rdata;
        error_d   = rsp_error;
        go_commit = 1'b0;
        arr_we    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_d   = req_live;
                    cnt_d   = CNT_INIT;
                    ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d   = COMMIT;
                        go_commit = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d   = COMMIT;
                    go_commit = 1'b1;
                end
            end
            COMMIT: begin
                arr_we  = req_q.write && !commit_err;
                rdata_d = (req_q.write || commit_err) ? '0 : arr_rdata;
                error_d = commit_err;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            req_ready <= ready_d;
            rsp_valid <= valid_d;
            rsp_rdata <= rdata_d;
            rsp_error <= error_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .CLK   (CLK),
        .we    (arr_we),
        .widx  (req_q.addr[BYTE_OFF_W +: IDX_W]),
        .wdata (req_q.wdata),
        .re    (arr_re),
        .ridx  (rd_req.addr[BYTE_OFF_W +: IDX_W]),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: fifteen responders (LATENCY 1..15) share one request stream and are
// checked against a per-latency doubleword memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int NL  = 15;
    localparam int WIN = 32;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        req_valid, req_write, rsp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [NL:1] rdy, vld, err;
    logic [63:0] rdata [1:NL];

    logic [63:0] mem_m [1:NL][WIN];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    genvar g;
    generate
        for (g = 1; g <= NL; g++) begin : g_dut
            dmem_responder #(
                .DEPTH   (DEPTH),
                .LATENCY (g)
            ) u_dut (
                .CLK       (CLK),
                .resetl    (resetl),
                .req_valid (req_valid),
                .req_ready (rdy[g]),
                .req_write (req_write),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .rsp_valid (vld[g]),
                .rsp_ready (rsp_ready),
                .rsp_rdata (rdata[g]),
                .rsp_error (err[g])
            );
        end
    endgenerate

    localparam logic [63:0] ALL1 = 64'({NL{1'b1}});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_err(input logic [63:0] a);
        return ((a % 64'd8) != 64'd0) || ((a / 64'd8) >= 64'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'(a / 64'd8);
    endfunction

    // In-window aligned address, or one of three error flavours.
    function automatic logic [63:0] rand_addr();
        int unsigned s;
        logic [63:0] a;
        s = $urandom_range(0, 9);
        a = 64'($urandom_range(0, WIN - 1)) * 64'd8;
        if (s == 0)      a = a | 64'($urandom_range(1, 7));
        else if (s == 1) a = a + 64'(DEPTH) * 64'd8;
        else if (s == 2) a = {($urandom() | 32'h1), $urandom()} & ~64'h7;
        return a;
    endfunction

    task automatic transact(input logic w, input logic [63:0] a, input logic [63:0] d);
        logic [NL:1] seen;
        logic [63:0] exp_rd [1:NL];
        logic        e;
        int          k;
        k = 0;
        while (rdy !== {NL{1'b1}} && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check("idle_before_req", 64'(rdy), ALL1);
        e = m_err(a);
        for (int L = 1; L <= NL; L++) begin
            exp_rd[L] = 64'd0;
            if (!w && !e) exp_rd[L] = mem_m[L][m_idx(a)];
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge CLK);
        req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
        req_addr  = {$urandom(), $urandom()}; req_wdata = {$urandom(), $urandom()};
        check("accept_all", 64'(rdy), 64'd0);
        seen = '0;
        for (int c = 1; c <= NL + 2; c++) begin
            @(negedge CLK);
            for (int L = 1; L <= NL; L++) begin
                if (vld[L] && !seen[L]) begin
                    seen[L] = 1'b1;
                    check($sformatf("latency_L%0d", L), 64'(c), 64'(L));
                    check($sformatf("rdata_L%0d_a%h", L, a), rdata[L], exp_rd[L]);
                    check($sformatf("error_L%0d_a%h", L, a), 64'(err[L]), 64'(e));
                end else if (c == L + 1) begin
                    check($sformatf("valid_one_cycle_L%0d", L), 64'(vld[L]), 64'd0);
                end
            end
        end
        check("all_responded", 64'(seen), ALL1);
        if (w && !e) begin
            for (int L = 1; L <= NL; L++) mem_m[L][m_idx(a)] = d;
        end
    endtask

    initial begin
        logic        have_acc;
        int          acc_c;
        logic [63:0] exp_l1;
        logic        exp_e1;

        resetl = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b1;
        req_addr = '0; req_wdata = '0;
        @(negedge CLK); @(negedge CLK);
        check("reset_req_ready", 64'(rdy), 64'd0);
        check("reset_rsp_valid", 64'(vld), 64'd0);
        check("reset_rsp_error", 64'(err), 64'd0);
        for (int L = 1; L <= NL; L++) check($sformatf("reset_rdata_L%0d", L), rdata[L], 64'd0);
        resetl = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", 64'(rdy), ALL1);

        for (int i = 0; i < WIN; i++) transact(1'b1, 64'(i * 8), 64'd0);

        transact(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
        transact(1'b0, 64'h10, 64'd0);
        transact(1'b1, 64'h13, 64'h1234_5678_9ABC_DEF0);
        transact(1'b0, 64'h10, 64'd0);
        transact(1'b0, 64'h2000, 64'd0);

        // Backpressure: responses held while rsp_ready stays low.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
        @(negedge CLK);
        req_valid = 1'b0; req_addr = 64'h18;
        repeat (NL + 1) @(negedge CLK);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_held", 64'(vld), ALL1);
            check("bp_ready_low", 64'(rdy), 64'd0);
            for (int L = 1; L <= NL; L++)
                check($sformatf("bp_rdata_L%0d", L), rdata[L], mem_m[L][2]);
            @(negedge CLK);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_ready_after_consume", 64'(rdy), ALL1);
        check("bp_valid_cleared", 64'(vld), 64'd0);

        // LATENCY=1 with req_valid and rsp_ready tied high; req_* churns every cycle.
        have_acc = 1'b0; acc_c = 0; exp_l1 = '0; exp_e1 = 1'b0;
        for (int c = 0; c < 36; c++) begin
            if (c > 0) begin
                check("l1_valid_pulse", 64'(vld[1]), 64'(have_acc && c == acc_c + 2));
                if (have_acc && c == acc_c + 2) begin
                    check("l1_rdata", rdata[1], exp_l1);
                    check("l1_error", 64'(err[1]), 64'(exp_e1));
                end
            end
            req_valid = 1'b1;
            req_write = (rdy == '0) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_addr  = rand_addr();
            req_wdata = {$urandom(), $urandom()};
            if (rdy[1]) begin
                if (have_acc) check("l1_accept_spacing", 64'(c - acc_c), 64'd3);
                have_acc = 1'b1;
                acc_c    = c;
                exp_e1   = m_err(req_addr);
                exp_l1   = exp_e1 ? 64'd0 : mem_m[1][m_idx(req_addr)];
            end
            @(negedge CLK);
        end
        req_valid = 1'b0; req_write = 1'b0;
        repeat (NL + 3) @(negedge CLK);
        check("drain_idle", 64'(rdy), ALL1);

        for (int i = 0; i < 40; i++)
            transact(1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()});

        // Reset two cycles into a store: only LATENCY<=2 has committed it.
        transact(1'b1, 64'h20, 64'd0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 resetl = 1'b0;
        #1;
        check("midreset_req_ready", 64'(rdy), 64'd0);
        check("midreset_rsp_valid", 64'(vld), 64'd0);
        check("midreset_rsp_error", 64'(err), 64'd0);
        for (int L = 1; L <= NL; L++) check($sformatf("midreset_rdata_L%0d", L), rdata[L], 64'd0);
        mem_m[1][4] = 64'h1;
        mem_m[2][4] = 64'h1;
        @(negedge CLK); @(negedge CLK);
        resetl = 1'b1;
        @(negedge CLK);
        check("midreset_ready_after_release", 64'(rdy), ALL1);
        transact(1'b0, 64'h20, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target side of the processor's data-memory interface: a doubleword data store that answers load/store requests from a multi-cycle initiator.
- Uses a valid/ready request channel, a programmable wait-state latency and a held response channel.
- Replaces the zero-latency data memory when the datapath is extended to stall on memory.
- One request is outstanding at a time, which keeps read-after-write ordering.

Parameters:
- DEPTH, 1024, number of 64-bit doublewords stored; power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- resetl  input  1  asynchronous active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- rsp_valid  output  1  response available; held until consumed.
- rsp_ready  input  1  initiator consumes the response.
- rsp_rdata  output  64  load data; 0 for stores and for errors.
- rsp_error  output  1  request was misaligned or out of range.

Behaviour:
- Reset (resetl low, asynchronous):
  - State goes to IDLE, the counter to 0, and all captured request registers to 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - Memory contents are not reset.
- First posedge after resetl rises: req_ready goes to 1. req_ready is a registered output.
- States:
  - IDLE: req_ready=1. On req_valid && req_ready, capture write/addr/wdata, load the counter with LATENCY-1, and clear req_ready. Go to WAIT, or go directly to COMMIT when LATENCY=1.
  - WAIT: the counter decrements each cycle. When it reaches 0, go to COMMIT.
  - COMMIT: lasts one cycle.
    - Perform the store to the array, or sample the array for a load.
    - Register rsp_rdata and rsp_error and set rsp_valid=1. Go to RESP.
  - RESP: hold rsp_valid, rsp_rdata and rsp_error stable. On rsp_ready, clear rsp_valid and set req_ready. Go to IDLE.
- Latency: rsp_valid rises exactly LATENCY cycles after the accepting edge.
- Throughput: the minimum accept-to-accept spacing is LATENCY+2 cycles when rsp_ready is held high.
- Address decode:
  - index = req_addr[3+log2(DEPTH)-1:3].
  - error = (req_addr[2:0] != 0) OR (req_addr >> 3 >= DEPTH).
  - On error: no array write, rsp_rdata=0, rsp_error=1.
- Stores: rsp_rdata=0, rsp_error per the decode. The array is updated on the COMMIT edge, so the next load sees the new value.
- req_valid outside IDLE is ignored. Changes to req_* after acceptance have no effect.
- rsp_ready outside RESP is ignored.
- rsp_ready already high when RESP is entered: the response is consumed on the first RESP edge. rsp_valid is high for exactly one cycle.
- Reset mid-operation:
  - A request not yet in COMMIT is dropped and no array write occurs.
  - A store already committed persists.
- Array: synchronous write, read sampled only in COMMIT. No combinational path from req_* to rsp_*.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum: IDLE, WAIT, COMMIT, RESP;
  - the doubleword width constant (64);
  - the byte-offset width constant (3);
  - the LATENCY legal-range bounds used by an elaboration-time check.
- One sub-module, dmem_array: a DEPTH x 64 storage element with a write port (we, index, wdata) and a registered read (re, index) returning rdata the following edge. The controller FSM and counter stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF_CAFEF00D → rsp_valid 2 cycles after accept, rsp_error=0, rsp_rdata=0.
  - Load addr 0x10 → rsp_rdata=0xDEADBEEF_CAFEF00D.
- Misaligned and out-of-range, DEPTH=1024:
  - Store to 0x13 → rsp_error=1, and a subsequent load of 0x10 is unchanged.
  - Load 0x2000 → rsp_error=1, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable and req_ready=0 throughout. rsp_ready=1 → req_ready=1 on the next cycle.
- LATENCY=1 with rsp_ready tied high and req_valid tied high:
  - Accepts occur every 3 cycles.
  - rsp_valid pulses one cycle after each accept.
  - req_* changes during WAIT/RESP are ignored.
- Reset mid-operation: accept a store to 0x20 (data 0x1) with LATENCY=4, and assert resetl low 2 cycles later.
  - All outputs go to 0 immediately and req_ready is 1 one cycle after release.
  - A load of 0x20 returns the prior value (0x0 when pre-initialised to 0).
- LATENCY sweep 1..15 → rsp_valid rise measured at exactly LATENCY cycles after accept.
